divisor_6bits: RTL and testbench

DIVISOR_6BITS -- requirements
Module: divisor_6bits

---
 rtl/divisor_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 16 +
 rtl/divisor_6bits.sv | 109 ++++++++++
 tb/tb_divisor_6bits.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared types and constants for the 6-bit signed divider.
// HEX drive is built only when DIVISOR_HEX_EN is defined.
package divisor_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DIV,
    DONE
  } state_t;

  localparam int ITERS = 6;

  // Active-low segments, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_GLYPH [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // 7 bits so that |-32| = 32 is representable
  function automatic logic [6:0] mag7(
    input logic [5:0] v
  );
    logic [6:0] x;
    x = {v[5], v};
    return v[5] ? 7'(-x) : x;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Decimal digit to active-low seven-segment glyph.
// Codes above 9 are shown blank.
module seg7_decoder
  import divisor_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= 4'd9)
      seg_o = SEG_GLYPH[digit_i];
  end

endmodule

// File: rtl/divisor_6bits.sv
// Signed 6-bit restoring divider, 7-edge latency, HEX readout.
// HEX decoders are built only when DIVISOR_HEX_EN is defined.
module divisor_6bits
  import divisor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic [5:0] Cociente,
  output logic [5:0] Residuo,
  output logic       neg,
  output logic [6:0] HEX_0,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  state_t     state_q;
  logic [5:0] a_raw_q, b_raw_q;
  logic [5:0] dvd_q, dvd_d;
  logic [6:0] dvs_q;
  logic [5:0] rem_q, rem_d;
  logic [2:0] cnt_q;
  logic       sgn_q, bz_q;
  logic [5:0] coc_q, res_q;
  logic       neg_q;

  logic [6:0] trial;
  logic       ge;

  // One restoring step; quotient bits shift into dvd from the right
  always_comb begin
    trial = {rem_q, dvd_q[5]};
    ge    = trial >= dvs_q;
    rem_d = ge ? 6'(trial - dvs_q) : 6'(trial);
    dvd_d = {dvd_q[4:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      a_raw_q <= '0;
      b_raw_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      bz_q    <= 1'b0;
      coc_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          a_raw_q <= A;
          b_raw_q <= B;
          dvd_q   <= 6'(mag7(A));
          dvs_q   <= mag7(B);
          rem_q   <= '0;
          sgn_q   <= A[5] ^ B[5];
          bz_q    <= (B == 6'd0);
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'(ITERS - 1)) begin
            coc_q   <= dvd_d;
            res_q   <= rem_d;
            neg_q   <= sgn_q & ~bz_q
                       & (dvd_d != 6'd0);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (A != a_raw_q || B != b_raw_q)
            state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign Cociente = coc_q;
  assign Residuo  = res_q;
  assign neg      = neg_q;

`ifdef DIVISOR_HEX_EN
  seg7_decoder u_ones (
    .digit_i (4'(coc_q % 6'd10)),
    .seg_o   (HEX_0)
  );

  seg7_decoder u_tens (
    .digit_i (4'(coc_q / 6'd10)),
    .seg_o   (HEX_1)
  );

  assign HEX_2 = neg_q ? SEG_MINUS : SEG_BLANK;
`else
  assign HEX_0 = SEG_BLANK;
  assign HEX_1 = SEG_BLANK;
  assign HEX_2 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_divisor_6bits.sv
// Directed self-checking bench for divisor_6bits.
// HEX expectations follow DIVISOR_HEX_EN.
module tb_divisor_6bits;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] A = '0;
  logic [5:0] B = '0;
  logic [5:0] Cociente, Residuo;
  logic       neg;
  logic [6:0] HEX_0, HEX_1, HEX_2;

  int checks = 0;
  int errors = 0;

`ifdef DIVISOR_HEX_EN
  localparam bit HEX_ON = 1'b1;
`else
  localparam bit HEX_ON = 1'b0;
`endif

  divisor_6bits dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Cociente (Cociente),
    .Residuo  (Residuo),
    .neg      (neg),
    .HEX_0    (HEX_0),
    .HEX_1    (HEX_1),
    .HEX_2    (HEX_2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hx(input logic [6:0] g);
    return HEX_ON ? g : 7'h7F;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    A = a;
    B = b;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    A = 6'd16;
    B = 6'd2;
    step(2);
    checks++;
    if ({Cociente, Residuo, neg} !== 13'd0) begin
      errors++;
      $display("FAIL reset_out: got %0d/%0d/%0d expected 0/0/0",
               Cociente, Residuo, neg);
    end
    checks++;
    if ({HEX_2, HEX_1, HEX_0} !== {7'h7F, hx(7'h40), hx(7'h40)}) begin
      errors++;
      $display("FAIL reset_hex: got %h %h %h expected %h %h %h",
               HEX_2, HEX_1, HEX_0, 7'h7F, hx(7'h40), hx(7'h40));
    end
  endtask

  task automatic test_latency;
    @(negedge clk);
    rst = 1'b1;
    step(6);
    checks++;
    if ({Cociente, Residuo, neg} !== 13'd0) begin
      errors++;
      $display("FAIL lat_hold: got %0d/%0d/%0d expected 0/0/0",
               Cociente, Residuo, neg);
    end
    step(1);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd8, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL 16/2: got %0d/%0d/%0d expected 8/0/0",
               Cociente, Residuo, neg);
    end
    checks++;
    if ({HEX_2, HEX_1, HEX_0} !== {7'h7F, hx(7'h40), hx(7'h00)}) begin
      errors++;
      $display("FAIL 16/2_hex: got %h %h %h expected %h %h %h",
               HEX_2, HEX_1, HEX_0, 7'h7F, hx(7'h40), hx(7'h00));
    end
  endtask

  task automatic test_back_to_back;
    start(6'b100010, 6'd4);
    step(7);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd8, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_hold: got %0d/%0d/%0d expected 8/0/0",
               Cociente, Residuo, neg);
    end
    step(1);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd7, 6'd2, 1'b1}) begin
      errors++;
      $display("FAIL -30/4: got %0d/%0d/%0d expected 7/2/1",
               Cociente, Residuo, neg);
    end
    checks++;
    if ({HEX_2, HEX_1, HEX_0} !== {hx(7'h3F), hx(7'h40), hx(7'h78)}) begin
      errors++;
      $display("FAIL -30/4_hex: got %h %h %h expected %h %h %h",
               HEX_2, HEX_1, HEX_0, hx(7'h3F), hx(7'h40), hx(7'h78));
    end
  endtask

  task automatic test_truncation;
    logic signed [7:0] wa, wb;
    wa = -8'sd120;
    wb = -8'sd80;
    start(wa[5:0], wb[5:0]);
    step(8);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd0, 6'd8, 1'b0}) begin
      errors++;
      $display("FAIL trunc: got %0d/%0d/%0d expected 0/8/0",
               Cociente, Residuo, neg);
    end
    checks++;
    if ({HEX_2, HEX_1, HEX_0} !== {7'h7F, hx(7'h40), hx(7'h40)}) begin
      errors++;
      $display("FAIL trunc_hex: got %h %h %h expected %h %h %h",
               HEX_2, HEX_1, HEX_0, 7'h7F, hx(7'h40), hx(7'h40));
    end
  endtask

  task automatic test_recompute;
    start(6'b100010, 6'd7);
    step(8);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd4, 6'd2, 1'b1}) begin
      errors++;
      $display("FAIL -30/7: got %0d/%0d/%0d expected 4/2/1",
               Cociente, Residuo, neg);
    end
    start(6'd31, 6'd7);
    step(7);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd4, 6'd2, 1'b1}) begin
      errors++;
      $display("FAIL recomp_hold: got %0d/%0d/%0d expected 4/2/1",
               Cociente, Residuo, neg);
    end
    step(1);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd4, 6'd3, 1'b0}) begin
      errors++;
      $display("FAIL 31/7: got %0d/%0d/%0d expected 4/3/0",
               Cociente, Residuo, neg);
    end
  endtask

  task automatic test_overflow;
    start(6'b100000, 6'b111111);
    step(8);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd32, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL -32/-1: got %0d/%0d/%0d expected 32/0/0",
               Cociente, Residuo, neg);
    end
    checks++;
    if ({HEX_2, HEX_1, HEX_0} !== {7'h7F, hx(7'h30), hx(7'h24)}) begin
      errors++;
      $display("FAIL -32/-1_hex: got %h %h %h expected %h %h %h",
               HEX_2, HEX_1, HEX_0, 7'h7F, hx(7'h30), hx(7'h24));
    end
  endtask

  task automatic test_div_zero;
    start(6'd5, 6'd0);
    step(7);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd32, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL div0_hold: got %0d/%0d/%0d expected 32/0/0",
               Cociente, Residuo, neg);
    end
    step(1);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd63, 6'd5, 1'b0}) begin
      errors++;
      $display("FAIL 5/0: got %0d/%0d/%0d expected 63/5/0",
               Cociente, Residuo, neg);
    end
    checks++;
    if ({HEX_2, HEX_1, HEX_0} !== {7'h7F, hx(7'h02), hx(7'h30)}) begin
      errors++;
      $display("FAIL 5/0_hex: got %h %h %h expected %h %h %h",
               HEX_2, HEX_1, HEX_0, 7'h7F, hx(7'h02), hx(7'h30));
    end
  endtask

  task automatic test_reset_mid_div;
    start(6'd20, 6'd3);
    step(4);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd63, 6'd5, 1'b0}) begin
      errors++;
      $display("FAIL mid_hold: got %0d/%0d/%0d expected 63/5/0",
               Cociente, Residuo, neg);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({Cociente, Residuo, neg} !== 13'd0) begin
      errors++;
      $display("FAIL async_rst: got %0d/%0d/%0d expected 0/0/0",
               Cociente, Residuo, neg);
    end
    @(negedge clk);
    rst = 1'b1;
    step(6);
    checks++;
    if ({Cociente, Residuo, neg} !== 13'd0) begin
      errors++;
      $display("FAIL post_rst_hold: got %0d/%0d/%0d expected 0/0/0",
               Cociente, Residuo, neg);
    end
    step(1);
    checks++;
    if ({Cociente, Residuo, neg} !== {6'd6, 6'd2, 1'b0}) begin
      errors++;
      $display("FAIL 20/3: got %0d/%0d/%0d expected 6/2/0",
               Cociente, Residuo, neg);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_truncation;
    test_recompute;
    test_overflow;
    test_div_zero;
    test_reset_mid_div;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
